// File: rtl/step_dir_generator.sv
// Step/dir pulse generator: runs counted moves at a fixed step period,
// with direction setup time, clean abort and a wrapping signed position.
module step_dir_generator #(
    parameter int COUNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               move_valid,
    output logic               move_ready,
    input  logic [COUNT_W-1:0] move_steps,
    input  logic               move_dir,
    input  logic [23:0]        move_period,
    input  logic [7:0]         config_pulse_width,
    input  logic [7:0]         config_dir_setup,
    input  logic               abort,
    output logic               step,
    output logic               dir,
    output logic               busy,
    output logic               done,
    output logic [COUNT_W-1:0] steps_remaining,
    output logic [COUNT_W-1:0] position
);

    typedef enum logic [1:0] {
        IDLE,
        DIR_SETUP,
        STEP_HIGH,
        STEP_LOW
    } state_t;

    localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

    state_t             r_state, w_state_nxt;
    logic [23:0]        r_cnt, w_cnt_nxt;
    logic [7:0]         r_high, w_high_nxt;
    logic [23:0]        r_low, w_low_nxt;
    logic               r_step, w_step_nxt;
    logic               r_dir, w_dir_nxt;
    logic               r_done, w_done_nxt;
    logic               r_abort_pend, w_abort_pend_nxt;
    logic [COUNT_W-1:0] r_rem, w_rem_nxt;
    logic [COUNT_W-1:0] r_pos, w_pos_nxt;

    logic               w_accept;
    logic               w_pend;
    logic [7:0]         w_in_high;
    logic [23:0]        w_in_low;
    logic [7:0]         w_in_setup_m1;
    logic [COUNT_W-1:0] w_pos_inc;

    assign w_accept      = move_valid && move_ready;
    assign w_in_high     = (config_pulse_width == 8'd0) ? 8'd1
                                                        : config_pulse_width;
    assign w_in_low      = (move_period > {16'd0, w_in_high})
                         ? move_period - {16'd0, w_in_high}
                         : 24'd1;
    assign w_in_setup_m1 = (config_dir_setup == 8'd0) ? 8'd0
                                                      : config_dir_setup - 8'd1;
    assign w_pos_inc     = r_dir ? r_pos + ONE : r_pos - ONE;
    assign w_pend        = r_abort_pend || abort;

    // Timer r_cnt counts down the remaining cycles of the current phase.
    always_comb begin
        w_state_nxt      = r_state;
        w_cnt_nxt        = r_cnt;
        w_high_nxt       = r_high;
        w_low_nxt        = r_low;
        w_step_nxt       = r_step;
        w_dir_nxt        = r_dir;
        w_done_nxt       = 1'b0;
        w_abort_pend_nxt = r_abort_pend;
        w_rem_nxt        = r_rem;
        w_pos_nxt        = r_pos;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_high_nxt       = w_in_high;
                    w_low_nxt        = w_in_low;
                    w_abort_pend_nxt = 1'b0;
                    w_rem_nxt        = move_steps;
                    if (move_steps == '0) begin
                        w_done_nxt = 1'b1;
                    end else if (move_dir != r_dir) begin
                        w_dir_nxt   = move_dir;
                        w_cnt_nxt   = {16'd0, w_in_setup_m1};
                        w_state_nxt = DIR_SETUP;
                    end else begin
                        w_state_nxt = STEP_HIGH;
                        w_step_nxt  = 1'b1;
                        w_rem_nxt   = move_steps - ONE;
                        w_pos_nxt   = w_pos_inc;
                        w_cnt_nxt   = {16'd0, w_in_high - 8'd1};
                    end
                end
            end
            DIR_SETUP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == 24'd0) begin
                    w_state_nxt = STEP_HIGH;
                    w_step_nxt  = 1'b1;
                    w_rem_nxt   = r_rem - ONE;
                    w_pos_nxt   = w_pos_inc;
                    w_cnt_nxt   = {16'd0, r_high - 8'd1};
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
            STEP_HIGH: begin
                // An abort here is remembered so the pulse always completes.
                if (r_cnt == 24'd0) begin
                    w_step_nxt       = 1'b0;
                    w_abort_pend_nxt = 1'b0;
                    if (w_pend) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = STEP_LOW;
                        w_cnt_nxt   = r_low - 24'd1;
                    end
                end else begin
                    w_cnt_nxt        = r_cnt - 24'd1;
                    w_abort_pend_nxt = w_pend;
                end
            end
            STEP_LOW: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (r_cnt == 24'd0) begin
                    if (r_rem != '0) begin
                        w_state_nxt = STEP_HIGH;
                        w_step_nxt  = 1'b1;
                        w_rem_nxt   = r_rem - ONE;
                        w_pos_nxt   = w_pos_inc;
                        w_cnt_nxt   = {16'd0, r_high - 8'd1};
                    end else begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 24'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cnt        <= 24'd0;
            r_high       <= 8'd1;
            r_low        <= 24'd1;
            r_step       <= 1'b0;
            r_dir        <= 1'b0;
            r_done       <= 1'b0;
            r_abort_pend <= 1'b0;
            r_rem        <= '0;
            r_pos        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_high       <= w_high_nxt;
            r_low        <= w_low_nxt;
            r_step       <= w_step_nxt;
            r_dir        <= w_dir_nxt;
            r_done       <= w_done_nxt;
            r_abort_pend <= w_abort_pend_nxt;
            r_rem        <= w_rem_nxt;
            r_pos        <= w_pos_nxt;
        end
    end

    assign move_ready      = (r_state == IDLE) && !reset;
    assign busy            = (r_state != IDLE);
    assign step            = r_step;
    assign dir             = r_dir;
    assign done            = r_done;
    assign steps_remaining = r_rem;
    assign position        = r_pos;

endmodule

// File: tb/tb_step_dir_generator.sv
// Bench for step_dir_generator: builds each move's expected waveform
// from phase lengths and compares every cycle.
module tb_step_dir_generator;

    logic        clk;
    logic        reset;
    logic        move_valid;
    logic        move_ready;
    logic [31:0] move_steps;
    logic        move_dir;
    logic [23:0] move_period;
    logic [7:0]  config_pulse_width;
    logic [7:0]  config_dir_setup;
    logic        abort;
    logic        step;
    logic        dir;
    logic        busy;
    logic        done;
    logic [31:0] steps_remaining;
    logic [31:0] position;

    int          errors;
    int          checks;
    logic [31:0] m_pos;
    logic        m_dir;

    step_dir_generator #(.COUNT_W(32)) dut (
        .clk                (clk),
        .reset              (reset),
        .move_valid         (move_valid),
        .move_ready         (move_ready),
        .move_steps         (move_steps),
        .move_dir           (move_dir),
        .move_period        (move_period),
        .config_pulse_width (config_pulse_width),
        .config_dir_setup   (config_dir_setup),
        .abort              (abort),
        .step               (step),
        .dir                (dir),
        .busy               (busy),
        .done               (done),
        .steps_remaining    (steps_remaining),
        .position           (position)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; returns at the negedge of the done cycle.
    task automatic run_move(input int n, input bit d, input int period,
                            input int pw, input int setup,
                            input int abort_at);
        int          h;
        int          l;
        int          s;
        int          pl;
        int          base;
        int          last;
        int          pulses;
        bit          q_st[$];
        bit          q_hi[$];
        int          q_pl[$];
        int          q_he[$];
        bit          e_step;
        bit          e_busy;
        bit          e_done;
        bit          e_dir;
        logic [31:0] delta;
        logic [31:0] e_pos;
        logic [31:0] e_rem;
        h  = (pw == 0) ? 1 : pw;
        l  = (period > h) ? period - h : 1;
        s  = (n > 0 && d != m_dir) ? ((setup == 0) ? 1 : setup) : 0;
        pl = 0;
        for (int i = 0; i < s; i++) begin
            q_st.push_back(1'b0); q_hi.push_back(1'b0);
            q_pl.push_back(0);    q_he.push_back(0);
        end
        for (int p = 1; p <= n; p++) begin
            pl++;
            base = q_st.size();
            for (int j = 0; j < h; j++) begin
                q_st.push_back(1'b1); q_hi.push_back(1'b1);
                q_pl.push_back(pl);   q_he.push_back(base + h);
            end
            for (int j = 0; j < l; j++) begin
                q_st.push_back(1'b0); q_hi.push_back(1'b0);
                q_pl.push_back(pl);   q_he.push_back(0);
            end
        end
        last = q_st.size();
        if (abort_at > 0 && abort_at <= last)
            last = q_hi[abort_at-1] ? q_he[abort_at-1] : abort_at;
        e_dir = (n > 0) ? d : m_dir;

        move_valid         = 1'b1;
        move_steps         = 32'(n);
        move_dir           = d;
        move_period        = 24'(period);
        config_pulse_width = 8'(pw);
        config_dir_setup   = 8'(setup);
        @(posedge clk);
        #1;
        move_valid         = 1'b0;
        move_steps         = $urandom;
        move_dir           = 1'($urandom);
        move_period        = 24'($urandom_range(1, 30));
        config_pulse_width = 8'($urandom);
        config_dir_setup   = 8'($urandom);

        for (int k = 1; k <= last + 1; k++) begin
            @(negedge clk);
            if (k <= last) begin
                e_step = q_st[k-1];
                pulses = q_pl[k-1];
                e_busy = 1'b1;
                e_done = 1'b0;
            end else begin
                e_step = 1'b0;
                pulses = (last > 0) ? q_pl[last-1] : 0;
                e_busy = 1'b0;
                e_done = 1'b1;
            end
            delta = 32'(pulses);
            e_pos = d ? m_pos + delta : m_pos - delta;
            e_rem = 32'(n) - delta;
            checks++;
            if (step !== e_step) begin
                errors++;
                $display("FAIL step cyc=%0d got=%b exp=%b", k, step, e_step);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", k, busy, e_busy);
            end
            checks++;
            if (done !== e_done) begin
                errors++;
                $display("FAIL done cyc=%0d got=%b exp=%b", k, done, e_done);
            end
            checks++;
            if (dir !== e_dir) begin
                errors++;
                $display("FAIL dir cyc=%0d got=%b exp=%b", k, dir, e_dir);
            end
            checks++;
            if (position !== e_pos) begin
                errors++;
                $display("FAIL position cyc=%0d got=%h exp=%h",
                         k, position, e_pos);
            end
            checks++;
            if (steps_remaining !== e_rem) begin
                errors++;
                $display("FAIL steps_remaining cyc=%0d got=%0d exp=%0d",
                         k, steps_remaining, e_rem);
            end
            if (k == last + 1) begin
                checks++;
                if (move_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL ready_at_done got=%b exp=1", move_ready);
                end
                m_pos = e_pos;
            end
            abort = (k == abort_at && k <= last);
        end
        abort = 1'b0;
        m_dir = e_dir;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || step !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL idle busy/step/done got=%b%b%b exp=000",
                         busy, step, done);
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        m_pos = '0;
        m_dir = 1'b0;
    endtask

    task automatic test_reset();
        move_valid = 1'b1;
        move_steps = 32'd5;
        @(negedge clk);
        checks++;
        if (step !== 1'b0) begin
            errors++; $display("FAIL rst_step got=%b exp=0", step);
        end
        checks++;
        if (dir !== 1'b0) begin
            errors++; $display("FAIL rst_dir got=%b exp=0", dir);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rst_busy got=%b exp=0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++; $display("FAIL rst_done got=%b exp=0", done);
        end
        checks++;
        if (move_ready !== 1'b0) begin
            errors++; $display("FAIL rst_ready got=%b exp=0", move_ready);
        end
        checks++;
        if (steps_remaining !== 32'd0) begin
            errors++;
            $display("FAIL rst_rem got=%0d exp=0", steps_remaining);
        end
        checks++;
        if (position !== 32'd0) begin
            errors++; $display("FAIL rst_pos got=%h exp=0", position);
        end
        move_valid = 1'b0;
        reset      = 1'b0;
        @(negedge clk);
        checks++;
        if (move_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL post_rst ready/busy got=%b%b exp=10",
                     move_ready, busy);
        end
        m_pos = '0;
        m_dir = 1'b0;
    endtask

    task automatic test_basic();
        run_move(3, 1'b1, 10, 2, 0, 0);
        checks++;
        if (position !== 32'd3) begin
            errors++; $display("FAIL basic_pos got=%0d exp=3", position);
        end
        idle_cycles(2);
    endtask

    task automatic test_dir_setup();
        run_move(2, 1'b0, 10, 2, 5, 0);
        checks++;
        if (position !== 32'd1 || dir !== 1'b0) begin
            errors++;
            $display("FAIL setup_pos/dir got=%0d/%b exp=1/0", position, dir);
        end
        idle_cycles(1);
    endtask

    task automatic test_fast();
        run_move(4, m_dir, 1, 0, 0, 0);
        idle_cycles(1);
    endtask

    task automatic test_abort_high();
        run_move(10, m_dir, 8, 3, 0, 3 * 8 + 1);
        checks++;
        if (steps_remaining !== 32'd6) begin
            errors++;
            $display("FAIL abort_high_rem got=%0d exp=6", steps_remaining);
        end
        idle_cycles(12);
    endtask

    task automatic test_abort_low_setup();
        run_move(5, m_dir, 10, 2, 0, 4);
        checks++;
        if (steps_remaining !== 32'd4) begin
            errors++;
            $display("FAIL abort_low_rem got=%0d exp=4", steps_remaining);
        end
        idle_cycles(1);
        run_move(5, ~m_dir, 10, 2, 6, 2);
        checks++;
        if (steps_remaining !== 32'd5) begin
            errors++;
            $display("FAIL abort_setup_rem got=%0d exp=5", steps_remaining);
        end
        idle_cycles(1);
    endtask

    task automatic test_wrap_zero();
        do_reset();
        run_move(1, 1'b0, 3, 1, 0, 0);
        checks++;
        if (position !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_down got=%h exp=ffffffff", position);
        end
        run_move(1, 1'b1, 3, 1, 2, 0);
        checks++;
        if (position !== 32'd0) begin
            errors++; $display("FAIL wrap_up got=%h exp=0", position);
        end
        run_move(0, 1'b0, 5, 1, 3, 0);
        checks++;
        if (dir !== 1'b1) begin
            errors++; $display("FAIL zero_dir got=%b exp=1", dir);
        end
        idle_cycles(2);
    endtask

    task automatic test_back_to_back();
        run_move(2, m_dir, 4, 1, 0, 0);
        run_move(3, m_dir, 3, 2, 0, 0);
        run_move(2, ~m_dir, 5, 2, 2, 0);
        idle_cycles(1);
    endtask

    task automatic test_idle_abort();
        abort = 1'b1;
        idle_cycles(4);
        abort = 1'b0;
    endtask

    task automatic test_random();
        int n;
        int ab;
        for (int it = 0; it < 30; it++) begin
            n  = $urandom_range(0, 6);
            ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 40) : 0;
            run_move(n, 1'($urandom_range(0, 1)), $urandom_range(1, 12),
                     $urandom_range(0, 5), $urandom_range(0, 4), ab);
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen               = 1'b0;
        move_valid         = 1'b1;
        move_steps         = 32'd5;
        move_dir           = ~m_dir;
        move_period        = 24'd6;
        config_pulse_width = 8'd3;
        config_dir_setup   = 8'd2;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = (step === 1'b1);
        end
        checks++;
        if (!seen) begin
            errors++; $display("FAIL reset_mid_timeout got=0 exp=1");
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (step !== 1'b0 || position !== 32'd0 || done !== 1'b0 ||
            busy !== 1'b0 || dir !== 1'b0 || steps_remaining !== 32'd0 ||
            move_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid step/done/busy/dir/rdy=%b%b%b%b%b pos=%h rem=%0d exp=00000/0/0",
                     step, done, busy, dir, move_ready, position,
                     steps_remaining);
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (move_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release ready/done got=%b%b exp=10",
                     move_ready, done);
        end
        m_pos = '0;
        m_dir = 1'b0;
        run_move(2, 1'b1, 4, 1, 1, 0);
    endtask

    initial begin
        errors             = 0;
        checks             = 0;
        m_pos              = '0;
        m_dir              = 1'b0;
        reset              = 1'b1;
        move_valid         = 1'b0;
        move_steps         = '0;
        move_dir           = 1'b0;
        move_period        = 24'd1;
        config_pulse_width = 8'd0;
        config_dir_setup   = 8'd0;
        abort              = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_basic();
        test_dir_setup();
        test_fast();
        test_abort_high();
        test_abort_low_setup();
        test_wrap_zero();
        test_back_to_back();
        test_idle_abort();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
